pong_input_conditioner: RTL and testbench

//  Turns the five raw push-buttons into the action bus and move strobe used by the

---
 rtl/pong_input_conditioner.sv | 162 ++++++++++++++++
 tb/tb_pong_input_conditioner.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/pong_input_conditioner.sv
// pong_input_conditioner
//   Conditions the five raw push-buttons for the Pong bar/ball engine.
//   Each button is synchronised, debounced and edge-detected. Bar buttons
//   also auto-repeat while held. Events are merged into an action word, and
//   each word is framed by the bandera strobe.
// Ports
//   Clock      in   25 MHz system clock
//   Reset      in   asynchronous, active-high reset
//   iBtn       in   [4:0] raw buttons, active-high
//                   [0]=start/pause [1]=bar1 left [2]=bar1 right
//                   [3]=bar0 right  [4]=bar0 left
//   mAccion    out  [4:0] action word; non-zero only inside a frame
//   bandera    out  move strobe; the engine samples mAccion on its rising edge
//   oBtnLevel  out  [4:0] debounced button levels
module pong_input_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned REPEAT_DELAY    = 5000000,
  parameter int unsigned REPEAT_RATE     = 2500000,
  parameter int unsigned STROBE_CYCLES   = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [4:0] iBtn,
  output logic [4:0] mAccion,
  output logic       bandera,
  output logic [4:0] oBtnLevel
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t      state, state_n;
  logic [4:0]  sync1, sync2, level_d;
  logic [31:0] dcnt [5];
  logic [31:0] rcnt [4:1];
  logic [4:1]  repeating;
  logic [4:0]  press, rfire, ev, pending, pending_n, cand, resolved;
  logic [4:0]  acc_n;
  logic        band_n;
  logic [31:0] scnt, scnt_n;

  // Synchroniser, debounce and previous-level register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1     <= '0;
      sync2     <= '0;
      oBtnLevel <= '0;
      level_d   <= '0;
      for (int unsigned i = 0; i < 5; i++) dcnt[i] <= '0;
    end else begin
      sync1   <= iBtn;
      sync2   <= sync1;
      level_d <= oBtnLevel;
      for (int unsigned i = 0; i < 5; i++) begin
        if (sync2[i] == oBtnLevel[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] >= 32'(DEBOUNCE_CYCLES - 1)) begin
          oBtnLevel[i] <= sync2[i];
          dcnt[i]      <= '0;
        end else if (dcnt[i] != '1) begin
          dcnt[i] <= dcnt[i] + 32'd1;
        end
      end
    end
  end

  // Events: press on debounced rise; repeats on bar bits while held.
  // rcnt holds the number of cycles since the last event on that bit.
  always_comb begin
    press = oBtnLevel & ~level_d;
    rfire = '0;
    for (int unsigned i = 1; i < 5; i++) begin
      rfire[i] = oBtnLevel[i] && !press[i] &&
                 (repeating[i] ? (rcnt[i] == 32'(REPEAT_RATE))
                               : (rcnt[i] == 32'(REPEAT_DELAY)));
    end
    ev = press | rfire;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      repeating <= '0;
      for (int unsigned i = 1; i < 5; i++) rcnt[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < 5; i++) begin
        if (!oBtnLevel[i]) begin
          rcnt[i]      <= '0;
          repeating[i] <= 1'b0;
        end else if (press[i]) begin
          rcnt[i]      <= 32'd1;
          repeating[i] <= 1'b0;
        end else if (rfire[i]) begin
          rcnt[i]      <= 32'd1;
          repeating[i] <= 1'b1;
        end else if (rcnt[i] != '1) begin
          rcnt[i] <= rcnt[i] + 32'd1;
        end
      end
    end
  end

  // Conflicting directions of one player cancel each other
  always_comb begin
    cand     = pending | ev;
    resolved = cand;
    if (cand[1] && cand[2]) resolved[2:1] = '0;
    if (cand[3] && cand[4]) resolved[4:3] = '0;
  end

  always_comb begin
    state_n   = state;
    scnt_n    = scnt;
    acc_n     = mAccion;
    band_n    = 1'b0;
    pending_n = pending | ev;
    case (state)
      IDLE: begin
        // Everything visible here is either issued or cancelled
        pending_n = '0;
        acc_n     = '0;
        if (resolved != '0) begin
          acc_n   = resolved;
          state_n = SETUP;
        end
      end
      SETUP: begin
        state_n = PULSE;
        scnt_n  = '0;
        band_n  = 1'b1;
      end
      PULSE: begin
        if (scnt >= 32'(STROBE_CYCLES - 1)) begin
          state_n = HOLD;
        end else begin
          scnt_n = scnt + 32'd1;
          band_n = 1'b1;
        end
      end
      HOLD: begin
        state_n = IDLE;
        acc_n   = '0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      scnt    <= '0;
      mAccion <= '0;
      bandera <= 1'b0;
      pending <= '0;
    end else begin
      state   <= state_n;
      scnt    <= scnt_n;
      mAccion <= acc_n;
      bandera <= band_n;
      pending <= pending_n;
    end
  end

endmodule

// File: tb/tb_pong_input_conditioner.sv
module tb_pong_input_conditioner;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic [4:0] iBtn  = '0;
  logic [4:0] mAccion;
  logic       bandera;
  logic [4:0] oBtnLevel;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  pong_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (8),
    .STROBE_CYCLES  (2)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .iBtn     (iBtn),
    .mAccion  (mAccion),
    .bandera  (bandera),
    .oBtnLevel(oBtnLevel)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  typedef struct {
    logic [4:0] word;
    int         at;
  } frame_t;

  frame_t q[$];

  typedef struct {
    logic [4:0] btn;
    int         hold;
    logic [4:0] lvl;
    logic [4:0] word;
    logic [4:0] rep;
  } vec_t;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Frame monitor: pops the scoreboard on each strobe rise, checks framing
  int         run = 0, bcnt = 0;
  logic       prev_b = 1'b0;
  logic [4:0] prev_m = '0;
  always @(negedge Clock) begin
    if (Reset) begin
      run = 0; bcnt = 0; prev_b = 1'b0; prev_m = '0;
    end else begin
      if (bandera && !prev_b) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_frame: actual mAccion=%0h at cycle %0d required no frame", mAccion, cyc);
        end else begin
          frame_t e;
          e = q.pop_front();
          check("frame_word", int'(mAccion), int'(e.word));
          check("frame_cycle", cyc, e.at);
        end
      end
      if (bandera && prev_b) check("stable_during_strobe", int'(mAccion), int'(prev_m));
      if (mAccion != '0) begin
        run++;
        if (bandera) bcnt++;
      end else if (run != 0) begin
        check("window_len", run, 4);
        check("strobe_len", bcnt, 2);
        run = 0; bcnt = 0;
      end
      prev_b = bandera;
      prev_m = mAccion;
    end
  end

  vec_t vecs[10];

  initial begin
    int k, off;
    vecs[0] = '{btn: 5'b00010, hold: 3,  lvl: 5'b00000, word: 5'b00000, rep: 5'b00000};
    vecs[1] = '{btn: 5'b00100, hold: 10, lvl: 5'b00100, word: 5'b00100, rep: 5'b00100};
    vecs[2] = '{btn: 5'b10000, hold: 60, lvl: 5'b10000, word: 5'b10000, rep: 5'b10000};
    vecs[3] = '{btn: 5'b00001, hold: 60, lvl: 5'b00001, word: 5'b00001, rep: 5'b00000};
    vecs[4] = '{btn: 5'b01010, hold: 10, lvl: 5'b01010, word: 5'b01010, rep: 5'b01010};
    vecs[5] = '{btn: 5'b00110, hold: 30, lvl: 5'b00110, word: 5'b00000, rep: 5'b00000};
    vecs[6] = '{btn: 5'b11000, hold: 10, lvl: 5'b11000, word: 5'b00000, rep: 5'b00000};
    vecs[7] = '{btn: 5'b00111, hold: 10, lvl: 5'b00111, word: 5'b00001, rep: 5'b00000};
    vecs[8] = '{btn: 5'b01001, hold: 30, lvl: 5'b01001, word: 5'b01001, rep: 5'b01000};
    vecs[9] = '{btn: 5'b00010, hold: 4,  lvl: 5'b00010, word: 5'b00010, rep: 5'b00010};

    tick(3);
    check("reset_mAccion", int'(mAccion), 0);
    check("reset_bandera", int'(bandera), 0);
    check("reset_level", int'(oBtnLevel), 0);
    Reset = 1'b0;
    tick(5);

    // Press reaches the engine as: 2 sync + 4 debounce + 1 edge + 1 setup
    for (int v = 0; v < 10; v++) begin
      k = cyc;
      if (vecs[v].word != '0) q.push_back('{word: vecs[v].word, at: k + 8});
      if (vecs[v].rep != '0) begin
        off = 20;
        while (off < vecs[v].hold) begin
          q.push_back('{word: vecs[v].rep, at: k + 8 + off});
          off += 8;
        end
      end
      iBtn = vecs[v].btn;
      tick(vecs[v].hold);
      iBtn = '0;
      tick(5);
      check("level_held", int'(oBtnLevel), int'(vecs[v].lvl));
      tick(15);
      check("level_released", int'(oBtnLevel), 0);
      check("frames_outstanding", q.size(), 0);
      q.delete();
      tick(5);
    end

    // Event arriving during PULSE waits and follows directly after HOLD
    k = cyc;
    q.push_back('{word: 5'b00010, at: k + 8});
    q.push_back('{word: 5'b01000, at: k + 13});
    iBtn = 5'b00010;
    tick(2);
    iBtn = 5'b01010;
    tick(10);
    iBtn = '0;
    tick(20);
    check("busy_outstanding", q.size(), 0);
    q.delete();

    // Reset in the middle of a strobe
    k = cyc;
    iBtn = 5'b00100;
    tick(8);
    check("pre_reset_strobe", int'(bandera), 1);
    Reset = 1'b1;
    iBtn  = '0;
    #1;
    check("midreset_bandera", int'(bandera), 0);
    check("midreset_mAccion", int'(mAccion), 0);
    tick(1);
    Reset = 1'b0;
    tick(30);
    check("post_reset_level", int'(oBtnLevel), 0);
    check("post_reset_outstanding", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
